// File: rtl/gate_response_checker.sv
// Response checker for a two-input NOR gate: compares c against ~(a|b) per sample and gives a verdict after NUM_VEC samples.
// `define GATE_CHK_COVER_EN to track input coverage and require all four {a,b} combinations for a pass.
// "cover" is a reserved word, so the coverage map leaves the block as cover_seen.
module gate_response_checker #(
  parameter int NUM_VEC = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vec_idx,
  output logic [2:0]       first_fail_vec,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [3:0]       cover_seen
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_match;
  logic             w_last;
  logic             w_clear;
  logic             w_coverOk;
  logic [CNT_W-1:0] w_passNext;
  logic [CNT_W-1:0] w_failNext;
  logic [CNT_W-1:0] r_passCnt;
  logic [CNT_W-1:0] r_failCnt;
  logic [CNT_W-1:0] r_vecIdx;
  logic [CNT_W-1:0] r_firstFailIdx;
  logic [2:0]       r_firstFailVec;
  logic             r_pass;

  assign w_accept = in_valid && (r_state == RUN);
  assign w_match  = (in_c == ~(in_a | in_b));
  assign w_last   = w_accept && (r_vecIdx == LAST_IDX);
  assign w_clear  = start && (r_state != RUN);

  // Saturating counters: they stop at all-ones rather than wrapping.
  assign w_passNext = (w_accept && w_match && r_passCnt != CNT_MAX) ? r_passCnt + 1'b1 : r_passCnt;
  assign w_failNext = (w_accept && !w_match && r_failCnt != CNT_MAX) ? r_failCnt + 1'b1 : r_failCnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start)  w_nextState = RUN;
      RUN:     if (w_last) w_nextState = DONE;
      DONE:    if (start)  w_nextState = RUN;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      RUN:  begin in_ready = 1'b1; busy = 1'b1; end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

`ifdef GATE_CHK_COVER_EN
  logic [3:0] r_cover;
  logic [3:0] w_coverNext;

  assign w_coverNext = r_cover | (4'b0001 << {in_a, in_b});
  assign w_coverOk   = (w_coverNext == 4'b1111);
  assign cover_seen  = r_cover;

  always_ff @(posedge clk) begin
    if (rst || w_clear) r_cover <= 4'b0000;
    else if (w_accept)  r_cover <= w_coverNext;
  end
`else
  assign w_coverOk  = 1'b1;
  assign cover_seen = 4'b0000;
`endif

  // The verdict uses next-cycle counts so it is valid on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_passCnt      <= '0;
      r_failCnt      <= '0;
      r_vecIdx       <= '0;
      r_firstFailIdx <= '0;
      r_firstFailVec <= 3'b000;
      r_pass         <= 1'b0;
    end else if (w_accept) begin
      r_passCnt <= w_passNext;
      r_failCnt <= w_failNext;
      r_vecIdx  <= r_vecIdx + 1'b1;
      if (!w_match && r_failCnt == '0) begin
        r_firstFailVec <= {in_a, in_b, in_c};
        r_firstFailIdx <= r_vecIdx;
      end
      if (w_last) r_pass <= (w_failNext == '0) && w_coverOk;
    end
  end

  assign pass           = r_pass;
  assign pass_cnt       = r_passCnt;
  assign fail_cnt       = r_failCnt;
  assign vec_idx        = r_vecIdx;
  assign first_fail_vec = r_firstFailVec;
  assign first_fail_idx = r_firstFailIdx;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed self-checking bench for gate_response_checker: a default instance and a CNT_W=2, NUM_VEC=3 instance.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       inValid = 1'b0;
  logic       inA = 1'b0;
  logic       inB = 1'b0;
  logic       inC = 1'b0;
  logic       inReady, busy, done, pass;
  logic [7:0] passCnt, failCnt, vecIdx, firstFailIdx;
  logic [2:0] firstFailVec;
  logic [3:0] coverSeen;

  logic       start2 = 1'b0;
  logic       inValid2 = 1'b0;
  logic       inA2 = 1'b0;
  logic       inB2 = 1'b0;
  logic       inC2 = 1'b0;
  logic       inReady2, busy2, done2, pass2;
  logic [1:0] passCnt2, failCnt2, vecIdx2, firstFailIdx2;
  logic [2:0] firstFailVec2;
  logic [3:0] coverSeen2;

  int testsRun = 0;
  int testsFailed = 0;
  logic [2:0] seq [8];
  logic [3:0] expCoverFull;
  logic [3:0] expCoverZero;
  logic       expPassAllZero;

  always #5 clk = ~clk;

  gate_response_checker #(.NUM_VEC(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(inValid),
    .in_a(inA), .in_b(inB), .in_c(inC),
    .in_ready(inReady), .busy(busy), .done(done), .pass(pass),
    .pass_cnt(passCnt), .fail_cnt(failCnt), .vec_idx(vecIdx),
    .first_fail_vec(firstFailVec), .first_fail_idx(firstFailIdx),
    .cover_seen(coverSeen)
  );

  gate_response_checker #(.NUM_VEC(3), .CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .start(start2), .in_valid(inValid2),
    .in_a(inA2), .in_b(inB2), .in_c(inC2),
    .in_ready(inReady2), .busy(busy2), .done(done2), .pass(pass2),
    .pass_cnt(passCnt2), .fail_cnt(failCnt2), .vec_idx(vecIdx2),
    .first_fail_vec(firstFailVec2), .first_fail_idx(firstFailIdx2),
    .cover_seen(coverSeen2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; drives one valid sample across one rising edge and returns at the next negedge.
  task automatic applyStimulus(input logic [2:0] abc);
    inA = abc[2]; inB = abc[1]; inC = abc[0]; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runSeq();
    for (int i = 0; i < 8; i++) applyStimulus(seq[i]);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(inReady), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_pass"}, 32'(pass), 0);
    checkOutput({tag, "_passCnt"}, 32'(passCnt), 0);
    checkOutput({tag, "_failCnt"}, 32'(failCnt), 0);
    checkOutput({tag, "_vecIdx"}, 32'(vecIdx), 0);
    checkOutput({tag, "_ffVec"}, 32'(firstFailVec), 0);
    checkOutput({tag, "_ffIdx"}, 32'(firstFailIdx), 0);
    checkOutput({tag, "_cover"}, 32'(coverSeen), 0);
  endtask

  initial begin
`ifdef GATE_CHK_COVER_EN
    expCoverFull = 4'b1111; expCoverZero = 4'b0001; expPassAllZero = 1'b0;
`else
    expCoverFull = 4'b0000; expCoverZero = 4'b0000; expPassAllZero = 1'b1;
`endif
    @(negedge clk);
    pulseReset();
    checkResetState("rst");

    // All-correct run covering every input combination.
    pulseStart();
    checkOutput("t1_ready", 32'(inReady), 1);
    checkOutput("t1_busy", 32'(busy), 1);
    seq = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b001, 3'b010, 3'b100, 3'b110};
    for (int i = 0; i < 7; i++) applyStimulus(seq[i]);
    checkOutput("t1_done_pre", 32'(done), 0);
    checkOutput("t1_vecIdx_pre", 32'(vecIdx), 7);
    applyStimulus(seq[7]);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_busy_done", 32'(busy), 0);
    checkOutput("t1_ready_done", 32'(inReady), 0);
    checkOutput("t1_pass", 32'(pass), 1);
    checkOutput("t1_passCnt", 32'(passCnt), 8);
    checkOutput("t1_failCnt", 32'(failCnt), 0);
    checkOutput("t1_vecIdx", 32'(vecIdx), 8);
    checkOutput("t1_cover", 32'(coverSeen), 32'(expCoverFull));
    applyStimulus(3'b000);
    checkOutput("t1_done_ignore", 32'(vecIdx), 8);
    checkOutput("t1_done_hold", 32'(failCnt), 0);

    // Start together with a valid sample from DONE: clears, sample not taken.
    inA = 1'b0; inB = 1'b0; inC = 1'b1; inValid = 1'b1;
    pulseStart();
    inValid = 1'b0;
    checkOutput("t2_clr_vecIdx", 32'(vecIdx), 0);
    checkOutput("t2_clr_passCnt", 32'(passCnt), 0);
    checkOutput("t2_clr_pass", 32'(pass), 0);
    checkOutput("t2_clr_cover", 32'(coverSeen), 0);
    seq = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b001, 3'b011, 3'b100, 3'b110};
    runSeq();
    checkOutput("t2_done", 32'(done), 1);
    checkOutput("t2_failCnt", 32'(failCnt), 2);
    checkOutput("t2_passCnt", 32'(passCnt), 6);
    checkOutput("t2_ffVec", 32'(firstFailVec), 32'h5);
    checkOutput("t2_ffIdx", 32'(firstFailIdx), 2);
    checkOutput("t2_pass", 32'(pass), 0);

    // All 00/1: correct but poor coverage.
    pulseStart();
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    runSeq();
    checkOutput("t3_passCnt", 32'(passCnt), 8);
    checkOutput("t3_failCnt", 32'(failCnt), 0);
    checkOutput("t3_cover", 32'(coverSeen), 32'(expCoverZero));
    checkOutput("t3_pass", 32'(pass), 32'(expPassAllZero));
    checkOutput("t3_ffIdx", 32'(firstFailIdx), 0);

    // Gapped valid with a start pulse mid-run that must be ignored.
    pulseStart();
    seq = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b110, 3'b100, 3'b010, 3'b001};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(seq[i]);
      if (i == 6) checkOutput("t4_done_pre", 32'(done), 0);
      if (i < 7) begin
        if (i == 3) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    checkOutput("t4_done", 32'(done), 1);
    checkOutput("t4_vecIdx", 32'(vecIdx), 8);
    checkOutput("t4_passCnt", 32'(passCnt), 8);
    checkOutput("t4_pass", 32'(pass), 1);

    // Reset in the middle of a run, then a clean run.
    pulseStart();
    seq = '{3'b001, 3'b011, 3'b100, 3'b110, 3'b001, 3'b010, 3'b100, 3'b110};
    for (int i = 0; i < 4; i++) applyStimulus(seq[i]);
    checkOutput("t5_mid_vecIdx", 32'(vecIdx), 4);
    checkOutput("t5_mid_failCnt", 32'(failCnt), 1);
    pulseReset();
    checkResetState("t5_rst");
    pulseStart();
    seq = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b001, 3'b010, 3'b100, 3'b110};
    runSeq();
    checkOutput("t5_passCnt", 32'(passCnt), 8);
    checkOutput("t5_pass", 32'(pass), 1);

    // Narrow instance: three failing samples reach the counter ceiling.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("t6_ready", 32'(inReady2), 1);
    seq = '{3'b000, 3'b111, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 3; i++) begin
      inA2 = seq[i][2]; inB2 = seq[i][1]; inC2 = seq[i][0]; inValid2 = 1'b1;
      @(negedge clk);
      inValid2 = 1'b0;
    end
    checkOutput("t6_done", 32'(done2), 1);
    checkOutput("t6_failCnt", 32'(failCnt2), 3);
    checkOutput("t6_passCnt", 32'(passCnt2), 0);
    checkOutput("t6_vecIdx", 32'(vecIdx2), 3);
    checkOutput("t6_ffIdx", 32'(firstFailIdx2), 0);
    checkOutput("t6_ffVec", 32'(firstFailVec2), 0);
    checkOutput("t6_pass", 32'(pass2), 0);
    inValid2 = 1'b1;
    @(negedge clk);
    inValid2 = 1'b0;
    checkOutput("t6_hold_fail", 32'(failCnt2), 3);
    checkOutput("t6_hold_idx", 32'(vecIdx2), 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
